mem_initiator: RTL and testbench
================================

MEM_INITIATOR -- requirements
Module: mem_initiator

Interface
REQ-001 Parameter READ_LATENCY, default 1, SHALL give the cycles from addr0 being driven to read_data being valid; legal range 1..4.
REQ-002 Parameter ADDR_STEP, default 4, SHALL give the address increment per burst beat.
REQ-003 UserCLK  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  in  1; req_ready  out  1: request handshake.
REQ-006 req_we  in  1  request type, 1=write, 0=read.
REQ-007 req_addr  in  32; req_wdata  in  32: request address and write data.
REQ-008 req_len  in  4  extra beats minus zero (burst length = req_len+1); present only with the configuration macro.
REQ-009 rsp_valid  out  1; rsp_ready  in  1: read-response handshake.
REQ-010 rsp_rdata  out  32; rsp_last  out  1: response data and final-beat flag.
REQ-011 addr0  out  32; write_data  out  32; write_en  out  1: Mem BEL command side.
REQ-012 read_data  in  32  Mem BEL read port; mem_reset  out  1  active-high Mem BEL reset.

Function
REQ-013 FSM states: IDLE, WRITE, RADDR, RWAIT, RESP.
REQ-014 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on a cycle with req_valid=1 and req_ready=1.
REQ-015 Accepted request: address, data, type and length SHALL be latched; next state WRITE if req_we=1, else RADDR.
REQ-016 WRITE: write_en=1, addr0=latched address, write_data=latched data for exactly one cycle; then IDLE; no response SHALL be produced.
REQ-017 write_en SHALL be 0 in every state except WRITE.
REQ-018 RADDR: addr0 driven with the beat address, a latency counter loaded with READ_LATENCY-1; next RWAIT.
REQ-019 RWAIT: addr0 held; counter decrements each cycle; at 0 read_data SHALL be captured into rsp_rdata and the state SHALL go to RESP.
REQ-020 Read latency from accept to rsp_valid SHALL be READ_LATENCY+2 cycles.
REQ-021 RESP: rsp_valid=1; rsp_rdata and rsp_last SHALL stay stable until rsp_ready=1.
REQ-022 RESP with rsp_ready=1: if the beat was the last, go to IDLE; otherwise address += ADDR_STEP (mod 2^32) and go to RADDR.
REQ-023 Without the macro, every read is a single beat and rsp_last SHALL be 1 whenever rsp_valid=1.
REQ-024 Address increment SHALL wrap from 0xFFFFFFFC to 0x00000000 without error.
REQ-025 req_valid while busy SHALL be ignored and not latched; the requester must hold it.
REQ-026 Writes SHALL ignore req_len (always one beat).

Reset
REQ-027 reset_n=0 SHALL asynchronously force IDLE, req_ready=0 while asserted, rsp_valid=0, rsp_last=0, write_en=0, addr0=0, write_data=0, rsp_rdata=0, counters=0.
REQ-028 mem_reset SHALL equal NOT reset_n.
REQ-029 Reset mid-burst or mid-write SHALL abandon the transaction without any further write_en pulse or response.
REQ-030 req_ready SHALL rise on the first UserCLK edge after reset_n deasserts.

Configuration
REQ-031 Macro MEM_INITIATOR_BURST_EN defined: req_len port exists; reads issue req_len+1 beats; rsp_last=1 only on the final beat.
REQ-032 Macro undefined: req_len port absent, beat counter logic removed, behaviour per REQ-023.

Verification
REQ-033 READ_LATENCY=1, write req addr 0x10 data 0xDEADBEEF -> write_en high for exactly one cycle with addr0=0x10, write_data=0xDEADBEEF; no rsp_valid.
REQ-034 READ_LATENCY=3, read addr 0x20, model returns 0x12345678 -> rsp_valid 5 cycles after accept, rsp_rdata=0x12345678, rsp_last=1.
REQ-035 Burst enabled, read addr 0xFFFFFFF8 req_len=2 -> addr0 sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; three responses, rsp_last only on third.
REQ-036 rsp_ready held 0 for 4 cycles in RESP -> rsp_valid and rsp_rdata stable; req_ready stays 0; new req_valid not accepted.
REQ-037 reset_n pulsed low during RWAIT of beat 2 of a 4-beat burst -> immediate IDLE, rsp_valid=0, write_en=0, mem_reset=1 during pulse; no further beats.
REQ-038 Back-to-back requests held valid -> second accepted on the cycle after the first returns to IDLE.

Source files
------------

// File: rtl/mem_initiator.sv
// Memory initiator: a valid/ready request port drives a Mem BEL (addr0/write_data/write_en),
// and read data comes back over a valid/ready response port. Macro MEM_INITIATOR_BURST_EN adds req_len bursts.
module mem_initiator #(
    parameter int READ_LATENCY = 1,   // cycles from addr0 to read_data, legal 1..4
    parameter int ADDR_STEP    = 4
) (
    input  logic        UserCLK,
    input  logic        reset_n,
    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // valid holds its payload stable until that edge, and ready never waits on valid.
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
`ifdef MEM_INITIATOR_BURST_EN
    input  logic [3:0]  req_len,
`endif
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_last,
    output logic [31:0] addr0,
    output logic [31:0] write_data,
    output logic        write_en,
    input  logic [31:0] read_data,
    output logic        mem_reset,
    output logic [2:0]  o_dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        RADDR = 3'd2,
        RWAIT = 3'd3,
        RESP  = 3'd4
    } state_t;

    localparam logic [1:0]  LAT_LOAD = 2'(READ_LATENCY - 1);
    localparam logic [31:0] STEP     = 32'(ADDR_STEP);

    state_t      r_state;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic        r_rsp_last;
    logic [31:0] r_rsp_rdata;
    logic [31:0] r_addr0;
    logic [31:0] r_write_data;
    logic        r_write_en;
    logic [1:0]  r_cnt;
    logic        w_accept;
    logic        w_last_beat;

`ifdef MEM_INITIATOR_BURST_EN
    logic [3:0]  r_beats_left;
    assign w_last_beat = (r_beats_left == 4'd0);
`else
    assign w_last_beat = 1'b1;
`endif

    assign w_accept = req_valid && r_req_ready;

    always_ff @(posedge UserCLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_req_ready  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_last   <= 1'b0;
            r_rsp_rdata  <= 32'h0;
            r_addr0      <= 32'h0;
            r_write_data <= 32'h0;
            r_write_en   <= 1'b0;
            r_cnt        <= 2'd0;
`ifdef MEM_INITIATOR_BURST_EN
            r_beats_left <= 4'd0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_req_ready  <= 1'b0;
                        r_addr0      <= req_addr;
                        r_write_data <= req_wdata;
                        if (req_we) begin
                            r_write_en <= 1'b1;
                            r_state    <= WRITE;
                        end else begin
`ifdef MEM_INITIATOR_BURST_EN
                            r_beats_left <= req_len;
`endif
                            r_state <= RADDR;
                        end
                    end
                end
                WRITE: begin
                    r_write_en  <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                RADDR: begin
                    r_cnt   <= LAT_LOAD;
                    r_state <= RWAIT;
                end
                RWAIT: begin
                    if (r_cnt == 2'd0) begin
                        r_rsp_rdata <= read_data;
                        r_rsp_valid <= 1'b1;
                        r_rsp_last  <= w_last_beat;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_last  <= 1'b0;
                        if (r_rsp_last) begin
                            r_req_ready <= 1'b1;
                            r_state     <= IDLE;
                        end else begin
                            // Address arithmetic wraps modulo 2^32 by width.
                            r_addr0 <= r_addr0 + STEP;
`ifdef MEM_INITIATOR_BURST_EN
                            r_beats_left <= r_beats_left - 4'd1;
`endif
                            r_state <= RADDR;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_last    = r_rsp_last;
    assign rsp_rdata   = r_rsp_rdata;
    assign addr0       = r_addr0;
    assign write_data  = r_write_data;
    assign write_en    = r_write_en;
    assign mem_reset   = ~reset_n;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_initiator.sv
// Scoreboarded bench for mem_initiator with a READ_LATENCY-deep registered memory model.
module tb_mem_initiator;
  localparam int RL   = 3;
  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_len;
  logic        rsp_valid, rsp_ready, rsp_last;
  logic [31:0] rsp_rdata, addr0, write_data, read_data;
  logic        write_en, mem_reset;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  mem_initiator #(.READ_LATENCY(RL), .ADDR_STEP(STEP)) dut (
    .UserCLK(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef MEM_INITIATOR_BURST_EN
    .req_len(req_len),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last),
    .addr0(addr0), .write_data(write_data), .write_en(write_en),
    .read_data(read_data), .mem_reset(mem_reset), .o_dbg_state(dbg_state)
  );

  // memory model: content is address-dependent so rdata also proves the addr0 sequence
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h20) ? 32'h12345678 : (a ^ 32'h5A5A5A5A);
  endfunction

  logic [31:0] pipe [RL];
  always @(posedge clk) begin
    pipe[0] <= mem_f(addr0);
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign read_data = pipe[RL-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] exp_q[$];
  logic [63:0] wr_q[$];
  int accept_cyc = 0;
  logic prev_we = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: compares every write pulse and response handshake against the queues
  always @(negedge clk) begin
    if (reset_n) begin
      if (write_en) begin
        chk("write_pulse_width", {63'd0, prev_we}, 64'd0);
        if (wr_q.size() == 0) chk("unexpected_write_en", {63'd0, write_en}, 64'd0);
        else chk("write_cmd", {addr0, write_data}, wr_q.pop_front());
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) chk("unexpected_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        else if (rsp_ready) chk("rsp_beat", {31'd0, rsp_last, rsp_rdata}, {31'd0, exp_q.pop_front()});
      end
      prev_we = write_en;
    end else begin
      prev_we = 1'b0;
    end
  end

  task automatic send_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] len);
    int budget = 0;
    int beats;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_len = len;
    while (!req_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!req_ready) begin
      chk("accept_timeout", {63'd0, req_ready}, 64'd1);
      req_valid = 1'b0;
      return;
    end
    accept_cyc = cyc;
    if (we) begin
      wr_q.push_back({a, d});
    end else begin
`ifdef MEM_INITIATOR_BURST_EN
      beats = int'(len) + 1;
`else
      beats = 1;
`endif
      for (int i = 0; i < beats; i++)
        exp_q.push_back({(i == beats - 1), mem_f(a + 32'(i * STEP))});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drop_req();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || wr_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_exp_q", 64'(exp_q.size()), 64'd0);
    chk("drain_wr_q", 64'(wr_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    int first;
    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_len = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_rsp", {62'd0, rsp_valid, rsp_last}, 64'd0);
    chk("rst_write_en", {63'd0, write_en}, 64'd0);
    chk("rst_addr_data", {addr0, write_data}, 64'd0);
    chk("rst_rdata", {32'd0, rsp_rdata}, 64'd0);
    chk("rst_mem_reset", {63'd0, mem_reset}, 64'd1);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {63'd0, req_ready}, 64'd1);
    chk("mem_reset_released", {63'd0, mem_reset}, 64'd0);

    // single write; req_len must not turn it into a burst
    send_req(1'b1, 32'h10, 32'hDEADBEEF, 4'd5);
    drop_req();
    drain();

    // read with latency check: accept cycle to first rsp_valid cycle
    send_req(1'b0, 32'h20, 32'h0, 4'd0);
    drop_req();
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("read_latency", 64'(cyc - accept_cyc), 64'(RL + 2));
    chk("read_rdata", {31'd0, rsp_last, rsp_rdata}, {31'd0, 1'b1, 32'h12345678});
    drain();

    // address wrap at the top of the address space
`ifdef MEM_INITIATOR_BURST_EN
    send_req(1'b0, 32'hFFFFFFF8, 32'h0, 4'd2);
`else
    send_req(1'b0, 32'hFFFFFFFC, 32'h0, 4'd0);
`endif
    drop_req();
    drain();

    // response stall with a competing request held valid
    rsp_ready = 1'b0;
    send_req(1'b0, 32'h30, 32'h0, 4'd0);
    drop_req();
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h44; req_wdata = 32'hCAFE0001;
    for (int i = 0; i < 4; i++) begin
      chk("stall_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("stall_rdata", {31'd0, rsp_last, rsp_rdata}, {31'd0, 1'b1, 32'h5A5A5A6A});
      chk("stall_req_ready", {63'd0, req_ready}, 64'd0);
      chk("stall_state", {61'd0, dbg_state}, 64'd4);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    send_req(1'b1, 32'h44, 32'hCAFE0001, 4'd0);
    drop_req();
    drain();

    // back-to-back writes held valid
    send_req(1'b1, 32'h50, 32'h11111111, 4'd0);
    first = accept_cyc;
    send_req(1'b1, 32'h54, 32'h22222222, 4'd0);
    chk("b2b_gap", 64'(accept_cyc - first), 64'd2);
    drop_req();
    drain();

    // reset asserted in the middle of a read transaction
`ifdef MEM_INITIATOR_BURST_EN
    send_req(1'b0, 32'h100, 32'h0, 4'd3);
    drop_req();
    n = 0;
    while (exp_q.size() != 3 && n < 60) begin
      @(negedge clk);
      n++;
    end
`else
    send_req(1'b0, 32'h100, 32'h0, 4'd0);
    drop_req();
`endif
    n = 0;
    while (dbg_state != 3'd3 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("reached_rwait", {61'd0, dbg_state}, 64'd3);
    @(posedge clk);
    #1 reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_state_idle", {61'd0, dbg_state}, 64'd0);
    chk("midrst_outputs", {60'd0, rsp_valid, write_en, req_ready, mem_reset}, 64'd1);
    chk("midrst_addr0", {32'd0, addr0}, 64'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_ready", {63'd0, req_ready}, 64'd1);

    // recovery after reset
    send_req(1'b0, 32'h200, 32'h0, 4'd0);
    drop_req();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
